// File: rtl/mm_job_arbiter.sv
// Round-robin arbiter that shares one matrix-multiply engine among NREQ requesters.
// Optional BUSY watchdog compiled in with `define MM_ARB_TIMEOUT_EN.
module mm_job_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [32*NREQ-1:0]   req_addr,
   input  logic [NREQ-1:0]      req_mode,
   output logic [NREQ-1:0]      rsp_done,
   output logic [NREQ-1:0]      rsp_err,
   output logic                 mm_start,
   output logic [31:0]          mm_addr,
   output logic                 mm_mode,
   input  logic                 mm_done,
   output logic                 busy,
   output logic [1:0]           grant_id
);

   localparam logic [15:0] LP_TMO = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_BUSY,
      S_RESP
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_last;
   logic [1:0]  r_owner;
   logic [31:0] r_addr;
   logic        r_mode;

   logic [1:0]  w_win;
   logic        w_any;
   int          w_best;
   int          w_dist;
   logic [31:0] w_sel_addr;
   logic        w_sel_mode;
   logic        w_hs;
   logic        w_tmo;
   logic        w_err;

   // Rotating priority: distance 0 is the port right after the last owner.
   always_comb begin
      w_win  = '0;
      w_any  = 1'b0;
      w_best = NREQ;
      w_dist = 0;
      for (int i = 0; i < NREQ; i++) begin
         w_dist = (i + NREQ - 1 - int'(r_last)) % NREQ;
         if (req_valid[i] && (w_dist < w_best)) begin
            w_best = w_dist;
            w_win  = 2'(i);
            w_any  = 1'b1;
         end
      end
   end

   always_comb begin
      w_sel_addr = '0;
      w_sel_mode = 1'b0;
      req_ready  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_win == 2'(i)) begin
            w_sel_addr   = req_addr[32*i +: 32];
            w_sel_mode   = req_mode[i];
            req_ready[i] = rst && (r_state == S_IDLE) && w_any;
         end
      end
   end

   assign w_hs = |(req_valid & req_ready);

   always_comb begin
      rsp_done = '0;
      rsp_err  = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_done[i] = (r_state == S_RESP) && (r_owner == 2'(i));
         rsp_err[i]  = (r_state == S_RESP) && (r_owner == 2'(i)) && w_err;
      end
   end

   always_comb begin
      w_next   = r_state;
      mm_start = 1'b0;
      busy     = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (w_hs) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            mm_start = 1'b1;
            w_next   = S_BUSY;
         end
         S_BUSY: begin
            if (mm_done || w_tmo) w_next = S_RESP;
         end
         S_RESP: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_last  <= 2'(NREQ - 1);
         r_owner <= '0;
         r_addr  <= '0;
         r_mode  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_hs) begin
            r_owner <= w_win;
            r_addr  <= w_sel_addr;
            r_mode  <= w_sel_mode;
         end
         if (r_state == S_RESP) r_last <= r_owner;
      end
   end

   assign mm_addr  = r_addr;
   assign mm_mode  = r_mode;
   assign grant_id = r_owner;

`ifdef MM_ARB_TIMEOUT_EN
   logic [15:0] r_cnt;
   logic        r_err;
   logic [15:0] w_cnt_inc;

   // w_cnt_inc is the number of BUSY cycles including the current one.
   assign w_cnt_inc = r_cnt + 16'd1;
   assign w_tmo     = (r_state == S_BUSY) && !mm_done
                      && (w_cnt_inc == LP_TMO);
   assign w_err     = r_err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state == S_ISSUE) begin
            r_cnt <= '0;
            r_err <= 1'b0;
         end else if (r_state == S_BUSY) begin
            r_cnt <= w_cnt_inc;
            if (w_next == S_RESP) r_err <= w_tmo;
         end
      end
   end
`else
   logic w_unused_tmo;

   assign w_unused_tmo = ^LP_TMO;
   assign w_tmo        = 1'b0;
   assign w_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Bench for mm_job_arbiter: directed steps plus randomized jobs
// checked against a job-level round-robin model.
module tb_mm_job_arbiter;

   localparam int NREQ = 2;
`ifdef MM_ARB_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 1023;
`endif

   logic                clk;
   logic                rst;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [32*NREQ-1:0]  req_addr;
   logic [NREQ-1:0]     req_mode;
   logic [NREQ-1:0]     rsp_done;
   logic [NREQ-1:0]     rsp_err;
   logic                mm_start;
   logic [31:0]         mm_addr;
   logic                mm_mode;
   logic                mm_done;
   logic                busy;
   logic [1:0]          grant_id;

   int          n_checks = 0;
   int          n_errors = 0;
   int          m_last;
   int          m_gid;
   logic [31:0] m_addr [NREQ];
   logic        m_mode [NREQ];

   mm_job_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_mode  (req_mode),
      .rsp_done  (rsp_done),
      .rsp_err   (rsp_err),
      .mm_start  (mm_start),
      .mm_addr   (mm_addr),
      .mm_mode   (mm_mode),
      .mm_done   (mm_done),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Spec rule: first valid port searching upward from last_grant+1.
   function automatic int pick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (last + k) % NREQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] oh(input int i);
      logic [NREQ-1:0] r;
      r = '0;
      if (i >= 0) r[i] = 1'b1;
      return r;
   endfunction

   task automatic load_inputs();
      for (int i = 0; i < NREQ; i++) begin
         m_addr[i] = $urandom;
         m_mode[i] = 1'($urandom_range(0, 1));
         req_addr[32*i +: 32] = m_addr[i];
         req_mode[i] = m_mode[i];
      end
   endtask

   task automatic scramble_inputs();
      for (int i = 0; i < NREQ; i++) begin
         req_addr[32*i +: 32] = $urandom;
         req_mode[i] = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_rdy"}, 32'(req_ready), 0);
      chk({tag, "_done"}, 32'(rsp_done), 0);
      chk({tag, "_err"}, 32'(rsp_err), 0);
      chk({tag, "_start"}, 32'(mm_start), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_addr"}, mm_addr, 0);
      chk({tag, "_mode"}, 32'(mm_mode), 0);
      chk({tag, "_gid"}, 32'(grant_id), 0);
   endtask

   // Called at a negedge; holds rst low for ncyc cycles.
   task automatic do_reset(input int ncyc);
      rst = 1'b0;
      req_valid = '1;
      mm_done = 1'b0;
      #1;
      check_quiet("rst");
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         check_quiet("rst_hold");
      end
      req_valid = '0;
      rst = 1'b1;
      m_last = NREQ - 1;
      m_gid = 0;
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge, idle.
   task automatic run_job(input logic [NREQ-1:0] v, input int dly,
                          input bit hold, input bit spur, input int want);
      int w;
      w = pick(v, m_last);
      req_valid = v;
      #1;
      chk("ready", 32'(req_ready), 32'(oh(w)));
      @(negedge clk);
      if (!hold) req_valid = '0;
      if (spur) mm_done = 1'b1;
      chk("start", 32'(mm_start), 1);
      chk("addr", mm_addr, m_addr[w]);
      chk("mode", 32'(mm_mode), 32'(m_mode[w]));
      chk("gid", 32'(grant_id), 32'(w));
      chk("rdy_issue", 32'(req_ready), 0);
      if (want >= 0) chk("order", 32'(grant_id), 32'(want));
      m_gid = w;
      scramble_inputs();
      @(negedge clk);
      mm_done = 1'b0;
      chk("start_off", 32'(mm_start), 0);
      chk("busy", 32'(busy), 1);
      chk("addr_hold", mm_addr, m_addr[w]);
      for (int c = 1; c < dly; c++) begin
         @(negedge clk);
         chk("wait_done", 32'(rsp_done), 0);
      end
      mm_done = 1'b1;
      @(negedge clk);
      mm_done = 1'b0;
      chk("done", 32'(rsp_done), 32'(oh(w)));
      chk("err", 32'(rsp_err), 0);
      chk("rdy_resp", 32'(req_ready), 0);
      m_last = w;
      @(negedge clk);
      chk("done_off", 32'(rsp_done), 0);
      chk("idle", 32'(busy), 0);
   endtask

   initial begin
      int w;
      int n;
      logic [NREQ-1:0] v;
      rst = 1'b0;
      req_valid = '0;
      req_addr = '0;
      req_mode = '0;
      mm_done = 1'b0;
      @(negedge clk);
      do_reset(2);

      // Single job with fixed address and mode
      load_inputs();
      m_addr[0] = 32'h0000_1000;
      m_mode[0] = 1'b1;
      req_addr[31:0] = m_addr[0];
      req_mode[0] = 1'b1;
      run_job(2'b01, 20, 1'b0, 1'b0, 0);

      // Contention right after reset: 0,1,0,1
      do_reset(1);
      load_inputs();
      run_job(2'b11, 3, 1'b1, 1'b0, 0);
      load_inputs();
      run_job(2'b11, 2, 1'b1, 1'b0, 1);
      load_inputs();
      run_job(2'b11, 4, 1'b1, 1'b0, 0);
      load_inputs();
      run_job(2'b11, 1, 1'b0, 1'b0, 1);

      // Spurious done in IDLE, then in ISSUE
      req_valid = '0;
      mm_done = 1'b1;
      @(negedge clk);
      mm_done = 1'b0;
      chk("spur_idle_busy", 32'(busy), 0);
      chk("spur_idle_done", 32'(rsp_done), 0);
      load_inputs();
      run_job(2'b10, 5, 1'b0, 1'b1, -1);

      // Request withdrawn before the clock edge
      load_inputs();
      req_valid = 2'b01;
      #1;
      chk("drop_ready", 32'(req_ready), 32'(oh(pick(2'b01, m_last))));
      #2;
      req_valid = '0;
      @(negedge clk);
      chk("drop_busy", 32'(busy), 0);
      chk("drop_gid", 32'(grant_id), 32'(m_gid));
      chk("drop_start", 32'(mm_start), 0);
      load_inputs();
      run_job(2'b11, 2, 1'b0, 1'b0, -1);

      // Randomized jobs
      for (int j = 0; j < 16; j++) begin
         load_inputs();
         v = 2'($urandom_range(1, 3));
         run_job(v, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), -1);
      end

      // Reset in the middle of a port-1 job
      load_inputs();
      req_valid = 2'b10;
      #1;
      chk("mid_ready", 32'(req_ready), 32'(oh(1)));
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      chk("mid_busy", 32'(busy), 1);
      @(negedge clk);
      do_reset(2);
      load_inputs();
      run_job(2'b11, 3, 1'b0, 1'b0, 0);

`ifdef MM_ARB_TIMEOUT_EN
      // Engine never answers: abort 9 cycles after mm_start
      load_inputs();
      w = pick(2'b01, m_last);
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = '0;
      chk("tmo_start", 32'(mm_start), 1);
      n = 0;
      while (n < 50 && rsp_done == '0) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_lat", 32'(n), 9);
      chk("tmo_done", 32'(rsp_done), 32'(oh(w)));
      chk("tmo_err", 32'(rsp_err), 32'(oh(w)));
      m_last = w;
      @(negedge clk);
      chk("tmo_off", 32'(rsp_done), 0);

      // Done arriving in the same cycle as the limit wins
      load_inputs();
      w = pick(2'b11, m_last);
      req_valid = 2'b11;
      @(negedge clk);
      req_valid = '0;
      n = 0;
      while (n < 50 && rsp_done == '0) begin
         @(negedge clk);
         n++;
         mm_done = (n == 8);
      end
      mm_done = 1'b0;
      chk("race_lat", 32'(n), 9);
      chk("race_done", 32'(rsp_done), 32'(oh(w)));
      chk("race_err", 32'(rsp_err), 0);
      m_last = w;
      @(negedge clk);
`else
      // No watchdog: BUSY holds for as long as done is withheld
      load_inputs();
      w = pick(2'b01, m_last);
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = '0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         chk("hold_busy", 32'(busy), 1);
         chk("hold_done", 32'(rsp_done), 0);
         chk("hold_err", 32'(rsp_err), 0);
      end
      mm_done = 1'b1;
      @(negedge clk);
      mm_done = 1'b0;
      chk("hold_fin", 32'(rsp_done), 32'(oh(w)));
      chk("hold_fin_err", 32'(rsp_err), 0);
      m_last = w;
      @(negedge clk);
`endif
      chk("end_idle", 32'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mm_job_arbiter.md
MM_JOB_ARBITER -- requirements
Module: mm_job_arbiter

Interface
REQ-001 Parameter NREQ, 2, number of requesters sharing the matrix-multiply engine (legal 2..4).
REQ-002 Parameter TIMEOUT, 1023, BUSY-state cycle limit before abort (16-bit, used only with MM_ARB_TIMEOUT_EN).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  NREQ  per-requester job request.
REQ-006 req_ready  out  NREQ  per-requester accept; one-hot or zero.
REQ-007 req_addr  in  32*NREQ  job base address; requester i in bits [32*i +: 32].
REQ-008 req_mode  in  NREQ  job mode bit per requester.
REQ-009 rsp_done  out  NREQ  one-cycle job-complete pulse to owning requester.
REQ-010 rsp_err  out  NREQ  abort flag, valid with rsp_done.
REQ-011 mm_start  out  1  one-cycle start pulse to engine.
REQ-012 mm_addr  out  32  engine base address, held from ISSUE through BUSY.
REQ-013 mm_mode  out  1  engine mode, held from ISSUE through BUSY.
REQ-014 mm_done  in  1  engine completion.
REQ-015 busy  out  1  high in any state except IDLE.
REQ-016 grant_id  out  2  index of current/last job owner.

Function
REQ-017 FSM states IDLE, ISSUE, BUSY, RESP; transitions IDLE->ISSUE on handshake, ISSUE->BUSY unconditional, BUSY->RESP on mm_done (or timeout), RESP->IDLE unconditional.
REQ-018 IDLE: winner = first i with req_valid[i], searching from (last_grant+1) mod NREQ upward with wrap; req_ready = one-hot(winner), zero if no valid.
REQ-019 req_ready SHALL be all-zero in ISSUE, BUSY, RESP.
REQ-020 Handshake = req_valid[i] & req_ready[i]; latches req_addr slice, req_mode[i], i into owner registers.
REQ-021 Requester dropping req_valid before handshake: no grant, no side effect.
REQ-022 ISSUE: mm_start=1 exactly one cycle; mm_addr/mm_mode driven from owner registers.
REQ-023 mm_done high in IDLE, ISSUE or RESP SHALL be ignored; only sampled in BUSY.
REQ-024 RESP: rsp_done[owner]=1 for one cycle, all other bits 0; last_grant <= owner.
REQ-025 Latency: handshake at edge t -> mm_start high cycle t+1; mm_done sampled at edge t+k -> rsp_done high cycle t+k+1; next handshake earliest edge t+k+2.
REQ-026 Single requester held valid back-to-back SHALL be re-granted when no other valid (round-robin never starves, never idles with pending request).
REQ-027 grant_id SHALL equal owner from ISSUE onward and hold through IDLE until next handshake.

Reset
REQ-028 rst low asynchronously forces IDLE; req_ready, rsp_done, rsp_err, mm_start, busy = 0; mm_addr = 0; mm_mode = 0; grant_id = 0; last_grant = NREQ-1 (port 0 highest priority first).
REQ-029 Reset mid-job SHALL drop the job with no rsp_done pulse; timeout counter cleared.

Configuration
REQ-030 Macro MM_ARB_TIMEOUT_EN defined: 16-bit counter cleared on ISSUE, increments each BUSY cycle; when count == TIMEOUT and mm_done low, go RESP with rsp_done[owner]=1 and rsp_err[owner]=1; mm_done and timeout same cycle -> normal completion, rsp_err=0.
REQ-031 Macro undefined: no counter; BUSY waits indefinitely for mm_done; rsp_err constant 0; TIMEOUT ignored.

Verification
REQ-032 Single job: req_valid=01, req_addr[0]=0x0000_1000, mode=1 -> req_ready=01 one cycle, mm_start pulse next cycle with mm_addr=0x1000, mm_mode=1; mm_done after 20 cycles -> rsp_done=01 one cycle later, rsp_err=00.
REQ-033 Contention: req_valid=11 held after reset -> grants in order 0,1,0,1 over four jobs; grant_id matches each.
REQ-034 Spurious done: mm_done pulsed in IDLE and in ISSUE cycle -> no state change, no rsp_done; job completes only on later BUSY mm_done.
REQ-035 Reset mid-BUSY: rst low for 2 cycles during job from port 1 -> all outputs zero, no rsp_done; after release, req_valid=11 grants port 0 first.
REQ-036 With MM_ARB_TIMEOUT_EN, TIMEOUT=8: mm_done never asserted -> rsp_done and rsp_err for owner exactly 9 cycles after mm_start; mm_done at count 8 -> rsp_err=0.
REQ-037 Without MM_ARB_TIMEOUT_EN: mm_done withheld 2000 cycles -> busy stays 1, no rsp_done, rsp_err=0 throughout.
